// File: rtl/sseg_pkg.sv
// Shared constants, types and helpers for the seven-segment scan driver.
package sseg_pkg;

    localparam logic [7:0] SSEG_BLANK = 8'hFF;
    localparam logic [3:0] ANODE_OFF  = 4'hF;
    localparam int         NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] bright_t;

    // Frame-synchronous copy of everything that shapes the picture.
    typedef struct packed {
        logic [NUM_DIGITS-1:0][7:0] pat;
        logic [NUM_DIGITS-1:0]      blank;
        bright_t                    bright;
    } shadow_t;

    localparam shadow_t SHADOW_RST = '{
        pat:    {NUM_DIGITS{SSEG_BLANK}},
        blank:  ANODE_OFF,
        bright: 4'd0
    };

    function automatic logic [3:0] anode_sel(input digit_idx_t idx);
        logic [3:0] a;
        a      = ANODE_OFF;
        a[idx] = 1'b0;
        return a;
    endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Slot counter and digit selector; derives the per-cycle timing qualifiers.
module sseg_slot_timer
    import sseg_pkg::*;
#(
    parameter int PRESCALE_W  = 18,
    parameter int DEAD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable_i,
    input  bright_t    bright_i,
    output digit_idx_t sel_o,
    output logic       wrap_o,
    output logic       frame_boundary_o,
    output logic       in_dead_o,
    output logic       duty_on_o
);

    localparam logic [PRESCALE_W-1:0] DEAD_LIM = PRESCALE_W'(DEAD_CYCLES);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    digit_idx_t            sel_q, sel_d;

    assign wrap_o           = (cnt_q == '1);
    assign frame_boundary_o = wrap_o && (sel_q == 2'd3);
    assign in_dead_o        = (cnt_q < DEAD_LIM);
    // The top four counter bits split the slot into 16 equal brightness steps.
    assign duty_on_o        = (cnt_q[PRESCALE_W-1 -: 4] <= bright_i);
    assign sel_o            = sel_q;

    always_comb begin
        cnt_d = '0;
        sel_d = '0;
        if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
            sel_d = wrap_o ? sel_q + 1'b1 : sel_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit common-anode scan driver with frame-latched inputs, blanking,
// 16-level PWM brightness and inter-digit dead time.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int PRESCALE_W  = 18,
    parameter int DEAD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic [3:0] blank,
    input  logic [3:0] bright,
    input  logic       enable,
    output logic [3:0] anode,
    output logic [7:0] cathode,
    output logic       frame_tick
);

    shadow_t    shadow_q, shadow_d;
    logic [3:0] anode_q, anode_d;
    logic [7:0] cathode_q, cathode_d;
    logic       frame_tick_q, frame_tick_d;

    digit_idx_t sel;
    logic       frame_boundary, in_dead, duty_on, digit_on;
    // Slot wrap is part of the timer's interface; only the frame edge matters here.
    logic       unused_wrap;

    sseg_slot_timer #(
        .PRESCALE_W  (PRESCALE_W),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_timer (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable_i         (enable),
        .bright_i         (shadow_q.bright),
        .sel_o            (sel),
        .wrap_o           (unused_wrap),
        .frame_boundary_o (frame_boundary),
        .in_dead_o        (in_dead),
        .duty_on_o        (duty_on)
    );

    assign digit_on = enable && !shadow_q.blank[sel] && !in_dead && duty_on;

    always_comb begin
        shadow_d = shadow_q;
        // While disabled the shadows track the inputs so a restart shows fresh data.
        if (!enable || frame_boundary) begin
            shadow_d.pat    = {in3, in2, in1, in0};
            shadow_d.blank  = blank;
            shadow_d.bright = bright;
        end
        anode_d      = digit_on ? anode_sel(sel)      : ANODE_OFF;
        cathode_d    = digit_on ? shadow_q.pat[sel]   : SSEG_BLANK;
        frame_tick_d = enable && frame_boundary;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q     <= SHADOW_RST;
            anode_q      <= ANODE_OFF;
            cathode_q    <= SSEG_BLANK;
            frame_tick_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench: frame-position model plus directed frame measurements.
module tb_sseg_scan_driver;

    localparam int PW = 6;
    localparam int DC = 2;
    localparam int S  = 64;
    localparam int FR = 4 * S;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in0, in1, in2, in3;
    logic [3:0] blank, bright;
    logic       enable;
    logic [3:0] anode;
    logic [7:0] cathode;
    logic       frame_tick;

    int checks = 0;
    int failures = 0;

    // model: absolute position within the frame plus latched picture
    int         pos;
    logic [7:0] m_pat[4];
    logic [3:0] m_blank, m_bright;
    logic [3:0] e_an;
    logic [7:0] e_ca;
    logic       e_tk;

    // per-frame measurements
    int         f_act[4];
    logic [7:0] f_cath[4];
    int         f_first0, f_mid_ticks;
    bit         f_tick_end;

    sseg_scan_driver #(.PRESCALE_W(PW), .DEAD_CYCLES(DC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .blank      (blank),
        .bright     (bright),
        .enable     (enable),
        .anode      (anode),
        .cathode    (cathode),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos = 0;
        for (int i = 0; i < 4; i++) m_pat[i] = 8'hFF;
        m_blank  = 4'hF;
        m_bright = 4'h0;
        e_an = 4'hF;
        e_ca = 8'hFF;
        e_tk = 1'b0;
    endtask

    // Predict the next registered outputs, clock once, compare.
    task automatic step();
        int cnt, sel;
        bit on, bnd;
        if (!reset_n) begin
            model_reset();
        end else begin
            cnt = pos % S;
            sel = pos / S;
            bnd = (pos == FR - 1);
            on  = enable && !m_blank[sel] && (cnt >= DC) && ((cnt / (S / 16)) <= int'(m_bright));
            e_an = on ? ~(4'b0001 << sel) : 4'hF;
            e_ca = on ? m_pat[sel] : 8'hFF;
            e_tk = enable && bnd;
            if (!enable || bnd) begin
                m_pat[0] = in0; m_pat[1] = in1; m_pat[2] = in2; m_pat[3] = in3;
                m_blank  = blank;
                m_bright = bright;
            end
            pos = enable ? (pos + 1) % FR : 0;
        end
        @(posedge clk);
        #1;
        chk("anode", 32'(anode), 32'(e_an));
        chk("cathode", 32'(cathode), 32'(e_ca));
        chk("frame_tick", 32'(frame_tick), 32'(e_tk));
    endtask

    // Run one frame window (256 samples following a tick) and measure it.
    task automatic run_frame(input int chg_at, input logic [7:0] chg_val);
        for (int d = 0; d < 4; d++) begin f_act[d] = 0; f_cath[d] = 8'hFF; end
        f_first0 = -1; f_mid_ticks = 0; f_tick_end = 0;
        for (int k = 1; k <= FR; k++) begin
            if (k == chg_at) in1 = chg_val;
            step();
            for (int d = 0; d < 4; d++) begin
                if (anode == ~(4'b0001 << d)) begin
                    f_act[d]++;
                    f_cath[d] = cathode;
                    if (d == 0 && f_first0 < 0) f_first0 = k;
                end
            end
            if (frame_tick) begin
                if (k == FR) f_tick_end = 1;
                else f_mid_ticks++;
            end
        end
    endtask

    task automatic chk_acts(input string nm, input int a0, input int a1, input int a2, input int a3);
        chk({nm, "_act0"}, 32'(f_act[0]), 32'(a0));
        chk({nm, "_act1"}, 32'(f_act[1]), 32'(a1));
        chk({nm, "_act2"}, 32'(f_act[2]), 32'(a2));
        chk({nm, "_act3"}, 32'(f_act[3]), 32'(a3));
    endtask

    initial begin
        int n, dark;
        in0 = 8'hFF; in1 = 8'hFF; in2 = 8'hFF; in3 = 8'hFF;
        blank = 4'hF; bright = 4'h0; enable = 1'b0;
        model_reset();

        repeat (3) step();
        chk("reset_anode", 32'(anode), 32'hF);
        chk("reset_cathode", 32'(cathode), 32'hFF);

        reset_n = 1'b1;
        enable = 1'b1;
        in0 = 8'hC0; in1 = 8'hF9; in2 = 8'hA4; in3 = 8'hB0;
        blank = 4'h0; bright = 4'hF;
        n = 0; dark = 0;
        while (!frame_tick && n < FR + 40) begin
            step();
            n++;
            if (anode != 4'hF) dark++;
        end
        chk("first_tick_latency", 32'(n), 32'(FR));
        chk("first_frame_dark", 32'(dark), 32'd0);

        // scan order and dead time; in1 changes mid-frame and must not tear
        run_frame(10, 8'h99);
        chk_acts("scan", 62, 62, 62, 62);
        chk("scan_cath0", 32'(f_cath[0]), 32'hC0);
        chk("scan_cath1_no_tear", 32'(f_cath[1]), 32'hF9);
        chk("scan_cath2", 32'(f_cath[2]), 32'hA4);
        chk("scan_cath3", 32'(f_cath[3]), 32'hB0);
        chk("scan_first0", 32'(f_first0), 32'd3);
        chk("scan_tick_period", 32'(f_tick_end), 32'd1);
        chk("scan_mid_ticks", 32'(f_mid_ticks), 32'd0);

        blank = 4'b0100;
        run_frame(0, 8'h00);
        chk("tear_cath1_new", 32'(f_cath[1]), 32'h99);
        chk_acts("preblank", 62, 62, 62, 62);

        blank = 4'h0; bright = 4'd3;
        run_frame(0, 8'h00);
        chk_acts("blank2", 62, 62, 0, 62);

        bright = 4'd0;
        run_frame(0, 8'h00);
        chk_acts("bright3", 14, 14, 14, 14);

        bright = 4'hF;
        run_frame(0, 8'h00);
        chk_acts("bright0", 2, 2, 2, 2);

        // enable drop at cnt=30 of digit-2 slot
        repeat (2 * S + 30) step();
        enable = 1'b0;
        in0 = 8'h92;
        repeat (10) step();
        chk("disabled_anode", 32'(anode), 32'hF);
        chk("disabled_cathode", 32'(cathode), 32'hFF);
        enable = 1'b1;
        run_frame(0, 8'h00);
        chk("restart_first0", 32'(f_first0), 32'd3);
        chk("restart_cath0", 32'(f_cath[0]), 32'h92);
        chk("restart_mid_ticks", 32'(f_mid_ticks), 32'd0);
        chk("restart_tick_end", 32'(f_tick_end), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 15))
                0: in0 = 8'($urandom);
                1: in1 = 8'($urandom);
                2: in2 = 8'($urandom);
                3: in3 = 8'($urandom);
                4: bright = 4'($urandom);
                5: blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                default: ;
            endcase
            if (enable && $urandom_range(0, 599) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
            step();
        end

        // asynchronous reset in the middle of an active digit
        enable = 1'b1; blank = 4'h0; bright = 4'hF;
        repeat (2 * FR) step();
        n = 0;
        while (anode == 4'hF && n < S) begin step(); n++; end
        chk("pre_reset_active", 32'(anode != 4'hF), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_anode", 32'(anode), 32'hF);
        chk("async_reset_cathode", 32'(cathode), 32'hFF);
        chk("async_reset_tick", 32'(frame_tick), 32'd0);
        model_reset();
        repeat (3) step();
        reset_n = 1'b1;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
